// File: rtl/mem_wb_stage_if.sv
// Memory-stage to writeback-stage handshake, including the data-SRAM response
// that the writeback stage holds its instruction for.
interface mem_wb_stage_if;
    logic         EXE_MEM_valid;
    logic [165:0] in_data;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         MEM_WB_allowin;
    logic         MEM_WB_valid;
    logic         wb_data_req_is_use;

    modport master (
        output EXE_MEM_valid, in_data, data_sram_data_ok, data_sram_rdata,
        input  MEM_WB_allowin, MEM_WB_valid, wb_data_req_is_use
    );

    modport slave (
        input  EXE_MEM_valid, in_data, data_sram_data_ok, data_sram_rdata,
        output MEM_WB_allowin, MEM_WB_valid, wb_data_req_is_use
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage: holds a memory-stage instruction until its SRAM response, builds the
// register/CSR writes and exception report. Define WB_DEBUG_TRACE_EN for debug trace ports.
module mem_wb_stage (
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave up,
    input  logic [31:0]   csr_rvalue,
    input  logic [63:0]   counter_value,
    input  logic [31:0]   counter_id,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic [13:0]   wb_csr_addr,
    output logic          wb_csr_we,
    output logic [31:0]   wb_csr_wdata,
    output logic [31:0]   wb_csr_wmask,
    output logic          wb_ex,
    output logic [5:0]    wb_ecode,
    output logic          wb_ertn,
    output logic [31:0]   wb_pc,
`ifdef WB_DEBUG_TRACE_EN
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_we,
    output logic [4:0]    debug_wb_rf_wnum,
    output logic [31:0]   debug_wb_rf_wdata,
`endif
    output logic [31:0]   wb_badv
);

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef struct packed {
        logic        res_from_mem;
        logic        mem_is_sign;
        logic [31:0] rkd_value;
        logic [31:0] alu_result;
        logic        is_byte;
        logic        is_halfword;
        logic        gr_we;
        logic [4:0]  dest;
        logic        res_from_counter;
        logic        counter_is_id;
        logic        counter_is_upper;
        logic        data_req_is_use;
        logic        res_from_csr;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] rj_value;
        logic        is_chg;
        logic        is_sys;
        logic        is_break;
        logic        is_ine;
        logic        is_adef;
        logic        is_ale;
        logic        is_interrupt;
        logic        is_ertn;
        logic [31:0] pc;
    } bundle_t;

    bundle_t     r;
    logic        valid;
    logic        done;
    logic        commit;
    logic        exc;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_value;

    // NOTE: the latched bundle is reset along with valid so every data output reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            r     <= '0;
        end else if (up.MEM_WB_allowin) begin
            valid <= up.EXE_MEM_valid;
            if (up.EXE_MEM_valid) begin
                r <= up.in_data;
            end
        end
    end

    // A stray data_ok is harmless: it only matters while a request is outstanding.
    assign done                  = !r.data_req_is_use | up.data_sram_data_ok;
    assign commit                = valid & done;
    assign up.MEM_WB_allowin     = !valid | done;
    assign up.MEM_WB_valid       = valid;
    assign up.wb_data_req_is_use = valid & r.data_req_is_use;

    assign exc = r.is_sys | r.is_break | r.is_ine | r.is_adef | r.is_ale | r.is_interrupt;

    always_comb begin
        case (r.alu_result[1:0])
            2'd0:    byte_lane = up.data_sram_rdata[7:0];
            2'd1:    byte_lane = up.data_sram_rdata[15:8];
            2'd2:    byte_lane = up.data_sram_rdata[23:16];
            default: byte_lane = up.data_sram_rdata[31:24];
        endcase
        half_lane = r.alu_result[1] ? up.data_sram_rdata[31:16] : up.data_sram_rdata[15:0];

        if (r.is_byte) begin
            load_value = {{24{r.mem_is_sign & byte_lane[7]}}, byte_lane};
        end else if (r.is_halfword) begin
            load_value = {{16{r.mem_is_sign & half_lane[15]}}, half_lane};
        end else begin
            load_value = up.data_sram_rdata;
        end
    end

    always_comb begin
        rf_wdata = r.alu_result;
        if (r.res_from_mem) begin
            rf_wdata = load_value;
        end else if (r.res_from_csr) begin
            rf_wdata = csr_rvalue;
        end else if (r.res_from_counter) begin
            if (r.counter_is_id) begin
                rf_wdata = counter_id;
            end else begin
                rf_wdata = r.counter_is_upper ? counter_value[63:32] : counter_value[31:0];
            end
        end
    end

    always_comb begin
        wb_ecode = ECODE_INT;
        if (r.is_interrupt) begin
            wb_ecode = ECODE_INT;
        end else if (r.is_adef) begin
            wb_ecode = ECODE_ADEF;
        end else if (r.is_ine) begin
            wb_ecode = ECODE_INE;
        end else if (r.is_sys) begin
            wb_ecode = ECODE_SYS;
        end else if (r.is_break) begin
            wb_ecode = ECODE_BRK;
        end else if (r.is_ale) begin
            wb_ecode = ECODE_ALE;
        end
    end

    assign rf_we        = commit & r.gr_we & !exc;
    assign rf_waddr     = r.dest;
    assign wb_csr_addr  = r.csr_addr;
    assign wb_csr_we    = commit & r.csr_we & !exc;
    assign wb_csr_wdata = r.rkd_value;
    assign wb_csr_wmask = r.is_chg ? r.rj_value : 32'hFFFF_FFFF;
    assign wb_ex        = commit & exc;
    assign wb_ertn      = commit & r.is_ertn & !exc;
    assign wb_pc        = r.pc;
    assign wb_badv      = r.is_adef ? r.pc : (r.is_ale ? r.alu_result : 32'h0);

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = r.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback stage directly downstream of the memory-access stage. It latches the memory-stage bundle, holds the instruction until its outstanding data-SRAM response (`data_sram_data_ok`) arrives, aligns and sign/zero-extends load data, selects the register-file write value, and reports exceptions/ERTN to the CSR unit. It also returns the `MEM_WB_allowin`, `MEM_WB_valid` and `wb_data_req_is_use` signals that the memory stage uses for its request gating and AXI blocking.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `EXE_MEM_valid` in 1: memory stage holds a valid instruction.
- `in_data` in 166: memory-stage bundle, MSB first:
  - `res_from_mem`, `mem_is_sign`, `rkd_value[32]`, `alu_result[32]`, `is_byte`, `is_halfword`, `gr_we`, `dest[5]`
  - `res_from_counter`, `counter_is_id`, `counter_is_upper`, `data_req_is_use`
  - `res_from_csr`, `csr_addr[14]`, `csr_we`, `rj_value[32]`, `is_chg`
  - `is_sys`, `is_break`, `is_ine`, `is_adef`, `is_ale`, `is_interrupt`, `is_ertn`
  - `pc[32]`
- `data_sram_data_ok` in 1: read/write response for the outstanding request.
- `data_sram_rdata` in 32: load data, valid with `data_sram_data_ok`.
- `csr_rvalue` in 32: combinational CSR read of `wb_csr_addr`.
- `counter_value` in 64: stable-counter value; `counter_id` in 32.
- `MEM_WB_allowin` out 1; `MEM_WB_valid` out 1; `wb_data_req_is_use` out 1.
- `rf_we` out 1; `rf_waddr` out 5; `rf_wdata` out 32.
- `wb_csr_addr` out 14; `wb_csr_we` out 1; `wb_csr_wdata` out 32; `wb_csr_wmask` out 32.
- `wb_ex` out 1; `wb_ecode` out 6; `wb_ertn` out 1; `wb_pc` out 32; `wb_badv` out 32.

## Operation
- Registers: `valid` and the latched bundle. On `MEM_WB_allowin & EXE_MEM_valid`, `valid` is set to 1 and the bundle is loaded. On `MEM_WB_allowin & !EXE_MEM_valid`, `valid` is cleared.
- `done = !data_req_is_use | data_sram_data_ok`.
- `MEM_WB_allowin = !valid | done`.
- `MEM_WB_valid = valid`.
- `wb_data_req_is_use = valid & data_req_is_use`.
- The state machine is implied by these registers:
  - EMPTY (`valid=0`).
  - WAIT (`valid & data_req_is_use & !data_ok`): holds.
  - COMMIT (`valid & done`): commits in this cycle.
- Transitions:
  - COMMIT → EMPTY when no new input arrives.
  - COMMIT → WAIT or COMMIT when a new instruction is accepted on the same edge.
- Load extension, using `alu_result[1:0]`:
  - Byte: select lane `rdata[8*a+7:8*a]`.
  - Halfword: select lane `rdata[16*a[1]+15:16*a[1]]`.
  - The selected lane is sign-extended if `mem_is_sign`, else zero-extended. Word loads pass through unchanged.
- `rf_wdata` priority:
  1. `res_from_mem` → load value.
  2. `res_from_csr` → `csr_rvalue`.
  3. `res_from_counter` → `counter_id` if `counter_is_id`, else the `counter_value` half chosen by `counter_is_upper`.
  4. Otherwise → `alu_result`.
- `exc = is_sys|is_break|is_ine|is_adef|is_ale|is_interrupt`.
- `rf_we = valid & done & gr_we & !exc`.
- `wb_csr_we = valid & done & csr_we & !exc`. `wb_csr_wdata = rkd_value`. `wb_csr_wmask = is_chg ? rj_value : 32'hFFFFFFFF`.
- `wb_ex = valid & done & exc`, one cycle.
- `wb_ecode` uses the first match in this priority: interrupt 0x00, adef 0x08, ine 0x0D, sys 0x0B, break 0x0C, ale 0x09.
- `wb_badv` = `pc` for adef, `alu_result` for ale, else 0.
- `wb_ertn = valid & done & is_ertn & !exc`.
- `data_sram_data_ok` is ignored while `valid=0` or `data_req_is_use=0`.

## Timing
- Reset values:
  - `valid=0`, so `MEM_WB_allowin=1`, `MEM_WB_valid=0`, `wb_data_req_is_use=0`.
  - All write enables, `wb_ex` and `wb_ertn` are 0.
  - The latched bundle is 0, so all data outputs are 0.
- Latency:
  - Non-memory instruction: commits in the cycle after acceptance.
  - Load/store: commits in the cycle `data_ok` is seen, at the earliest the cycle after acceptance.
  - No bubble: back-to-back acceptance at one instruction per cycle when `done=1`.
- `data_ok` and a new acceptance can occur in the same cycle: the current instruction commits and the new one loads on that edge.
- Reset mid-WAIT clears `valid` immediately. A later stray `data_ok` is ignored.

## Configuration
- `WB_DEBUG_TRACE_EN` defined: adds four outputs:
  - `debug_wb_pc` [32] = `pc`.
  - `debug_wb_rf_we` [4] = `{4{rf_we}}`.
  - `debug_wb_rf_wnum` [5] = `rf_waddr`.
  - `debug_wb_rf_wdata` [32] = `rf_wdata`.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset mid-WAIT (`ld.w` accepted, no `data_ok`) → `valid=0`, `allowin=1` next cycle. A `data_ok` two cycles later → no `rf_we`.
- `add`: `alu_result=0x12345678`, `dest=5`, `gr_we=1` → `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x12345678` one cycle after acceptance; `allowin` stays 1.
- `ld.b`, signed, addr `0x...3`, `rdata=0x80FFFFFF`, `data_ok` 3 cycles late:
  - While waiting: `MEM_WB_allowin=0`, `wb_data_req_is_use=1`.
  - On `data_ok`: `rf_wdata=0xFFFFFF80`.
  - Same `ld.b` with `mem_is_sign=0` gives `0x00000080`.
- `ld.hu` at addr offset 2, `rdata=0xBEEF0000` → `0x0000BEEF`. `st.w` with `data_ok` → commits, `rf_we=0`.
- `is_ale=1`, `alu_result=0x1002`, `gr_we=1` → `wb_ex=1`, `wb_ecode=0x09`, `wb_badv=0x1002`, `rf_we=0`.
- `csrxchg`: `rkd=0xA5`, `rj=0x0F` → `wb_csr_we=1`, `wb_csr_wmask=0x0F`, `rf_wdata=csr_rvalue`. Back-to-back with `data_ok`, the next instruction is accepted in the same cycle.
